// File: rtl/forward_scoreboard_if.sv
// Issue-side bundle between the ID stage and the operand scoreboard.
interface forward_scoreboard_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_W      = 16
);
    localparam int unsigned SEL_W = $clog2(DEPTH + 1);
    localparam int unsigned LAT_W = $clog2(DEPTH + 1);

    logic                          adv_i;
    logic                          flush_i;
    logic                          issue_valid_i;
    logic                          dst_we_i;
    logic [REG_ADDR_W-1:0]         dst_rd_i;
    logic [LAT_W-1:0]              dst_lat_i;
    logic [NUM_SRC*REG_ADDR_W-1:0] src_rd_i;
    logic [NUM_SRC-1:0]            src_used_i;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o;
    logic [NUM_SRC-1:0]            hazard_o;
    logic                          stall_o;
    logic [CNT_W-1:0]              stall_cnt_o;

    // Issue logic drives the instruction, reads back bypass selects and stall.
    modport master (
        output adv_i, flush_i, issue_valid_i, dst_we_i, dst_rd_i, dst_lat_i,
               src_rd_i, src_used_i,
        input  fwd_sel_o, hazard_o, stall_o, stall_cnt_o
    );

    // Scoreboard side.
    modport slave (
        input  adv_i, flush_i, issue_valid_i, dst_we_i, dst_rd_i, dst_lat_i,
               src_rd_i, src_used_i,
        output fwd_sel_o, hazard_o, stall_o, stall_cnt_o
    );
endinterface

// File: rtl/forward_scoreboard.sv
// Issue-stage operand scoreboard: tracks in-flight writes of variable latency,
// selects the youngest ready producer for bypass, and stalls on unready ones.
module forward_scoreboard #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    forward_scoreboard_if.slave sb
);
    localparam int unsigned SEL_W = $clog2(DEPTH + 1);
    localparam int unsigned LAT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]         r_valid;
    logic [REG_ADDR_W-1:0]    r_rd  [DEPTH];
    logic [LAT_W-1:0]         r_rem [DEPTH];
    logic [CNT_W-1:0]         r_cnt;

    logic [LAT_W-1:0]         w_lat;
    logic                     w_push;
    logic                     w_stall;
    logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
    logic [NUM_SRC-1:0]       w_hazard;

    // Latency clamp: 0 behaves as a single-cycle op, anything past DEPTH as DEPTH.
    always_comb begin
        w_lat = sb.dst_lat_i;
        if (sb.dst_lat_i == '0) begin
            w_lat = LAT_W'(1);
        end else if (sb.dst_lat_i > LAT_W'(DEPTH)) begin
            w_lat = LAT_W'(DEPTH);
        end
    end

    // Per-source lookup; descending scan so the youngest matching slot wins.
    always_comb begin
        w_fwd_sel = '0;
        w_hazard  = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            logic [REG_ADDR_W-1:0] v_src;
            v_src = sb.src_rd_i[s*REG_ADDR_W +: REG_ADDR_W];
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (sb.src_used_i[s] && (v_src != '0) && r_valid[k] && (r_rd[k] == v_src)) begin
                    if (r_rem[k] == '0) begin
                        w_fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k + 1);
                        w_hazard[s]                 = 1'b0;
                    end else begin
                        w_fwd_sel[s*SEL_W +: SEL_W] = '0;
                        w_hazard[s]                 = 1'b1;
                    end
                end
            end
        end
    end

    // Stall and slot-0 allocation; writes to x0 never occupy a slot.
    always_comb begin
        w_stall = sb.issue_valid_i & (|w_hazard);
        w_push  = sb.issue_valid_i & sb.dst_we_i & (sb.dst_rd_i != '0) & ~w_stall;
    end

    // Slot shift register: advance ages entries, freeze holds, flush empties.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k]  <= '0;
                r_rem[k] <= '0;
            end
        end else if (sb.flush_i) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rem[k] <= '0;
            end
        end else if (sb.adv_i) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_rd[k]    <= r_rd[k-1];
                r_rem[k]   <= (r_rem[k-1] == '0) ? '0 : (r_rem[k-1] - LAT_W'(1));
            end
            r_valid[0] <= w_push;
            r_rd[0]    <= w_push ? sb.dst_rd_i : '0;
            r_rem[0]   <= w_push ? (w_lat - LAT_W'(1)) : '0;
        end
    end

    // Saturating count of stall cycles that actually cost an advance.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (w_stall && sb.adv_i && !sb.flush_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign sb.fwd_sel_o   = w_fwd_sel;
    assign sb.hazard_o    = w_hazard;
    assign sb.stall_o     = w_stall;
    assign sb.stall_cnt_o = r_cnt;
endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard: directed scenarios plus random traffic,
// all checked against an age/latency model of the in-flight writes.
module tb_forward_scoreboard;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_SRC    = 2;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned SEL_W      = $clog2(DEPTH + 1);
    localparam int          CNT_MAX    = (1 << CNT_W) - 1;

    logic clk_i;
    logic rst_i;

    forward_scoreboard_if #(
        .REG_ADDR_W(REG_ADDR_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) sbif ();

    forward_scoreboard #(
        .REG_ADDR_W(REG_ADDR_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .sb    (sbif)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Model: list of issue events, index 0 = most recent advance.
    typedef struct {
        bit v;
        int rd;
        int lat;
    } ent_t;
    ent_t q[$];
    int   m_cnt;

    int nasrt = 0;
    int nfail = 0;

    // Values observed at the last sampling point.
    logic [NUM_SRC*SEL_W-1:0] o_sel;
    logic [NUM_SRC-1:0]       o_haz;
    logic                     o_stall;
    logic [CNT_W-1:0]         o_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < int'(DEPTH); i++) q.push_back('{v: 1'b0, rd: 0, lat: 0});
        m_cnt = 0;
    endtask

    function automatic int clamp_lat(input int lat);
        if (lat == 0) return 1;
        if (lat > int'(DEPTH)) return int'(DEPTH);
        return lat;
    endfunction

    // A write issued i advances ago is ready once i >= lat-1.
    function automatic void model_eval(output logic [NUM_SRC*SEL_W-1:0] esel,
                                       output logic [NUM_SRC-1:0] ehaz,
                                       output logic est);
        esel = '0;
        ehaz = '0;
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            int rd;
            rd = int'(sbif.src_rd_i[s*REG_ADDR_W +: REG_ADDR_W]);
            if (sbif.src_used_i[s] && rd != 0) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].v && q[i].rd == rd) begin
                        if (i >= q[i].lat - 1) esel[s*SEL_W +: SEL_W] = SEL_W'(i + 1);
                        else                   ehaz[s] = 1'b1;
                        break;
                    end
                end
            end
        end
        est = sbif.issue_valid_i & (|ehaz);
    endfunction

    task automatic model_edge();
        logic [NUM_SRC*SEL_W-1:0] esel;
        logic [NUM_SRC-1:0]       ehaz;
        logic                     est;
        bit                       push;
        if (!rst_i) begin
            model_reset();
            return;
        end
        model_eval(esel, ehaz, est);
        if (sbif.flush_i) begin
            foreach (q[i]) q[i].v = 1'b0;
            return;
        end
        if (!sbif.adv_i) return;
        if (est && m_cnt < CNT_MAX) m_cnt++;
        push = sbif.issue_valid_i && sbif.dst_we_i && sbif.dst_rd_i != '0 && !est;
        q.push_front('{v: push, rd: int'(sbif.dst_rd_i), lat: clamp_lat(int'(sbif.dst_lat_i))});
        void'(q.pop_back());
    endtask

    task automatic drive(input bit iv, input bit we, input int rd, input int lat,
                         input int s0, input int s1, input bit [1:0] used,
                         input bit adv = 1'b1, input bit fl = 1'b0);
        sbif.issue_valid_i = iv;
        sbif.dst_we_i      = we;
        sbif.dst_rd_i      = REG_ADDR_W'(rd);
        sbif.dst_lat_i     = 3'(lat);
        sbif.src_rd_i      = {REG_ADDR_W'(s1), REG_ADDR_W'(s0)};
        sbif.src_used_i    = used;
        sbif.adv_i         = adv;
        sbif.flush_i       = fl;
    endtask

    // Sample on the falling edge, then apply the rising edge to the model.
    task automatic tick();
        logic [NUM_SRC*SEL_W-1:0] esel;
        logic [NUM_SRC-1:0]       ehaz;
        logic                     est;
        @(negedge clk_i);
        o_sel   = sbif.fwd_sel_o;
        o_haz   = sbif.hazard_o;
        o_stall = sbif.stall_o;
        o_cnt   = sbif.stall_cnt_o;
        model_eval(esel, ehaz, est);
        chk("fwd_sel", 32'(o_sel), 32'(esel));
        chk("hazard", 32'(o_haz), 32'(ehaz));
        chk("stall", 32'(o_stall), 32'(est));
        chk("stall_cnt", 32'(o_cnt), 32'(m_cnt));
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    initial begin
        int cnt_a;
        rst_i = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        // Reset: outputs quiet even with a consumer presented.
        drive(1, 0, 0, 1, 5, 5, 2'b11);
        tick();
        chk("reset_sel", 32'(o_sel), 0);
        chk("reset_stall", 32'(o_stall), 0);
        chk("reset_cnt", 32'(o_cnt), 0);
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        tick();

        // T1 ALU chain
        drive(1, 1, 5, 1, 0, 0, 2'b00);
        tick();
        drive(1, 0, 0, 1, 5, 0, 2'b01);
        tick();
        chk("T1_sel0", 32'(o_sel[SEL_W-1:0]), 1);
        chk("T1_stall", 32'(o_stall), 0);

        // T2 load-use
        drive(1, 1, 7, 2, 0, 0, 2'b00);
        tick();
        drive(1, 0, 0, 1, 0, 7, 2'b10);
        tick();
        chk("T2_stall", 32'(o_stall), 1);
        chk("T2_haz", 32'(o_haz), 32'h2);
        tick();
        chk("T2_sel1", 32'(o_sel[2*SEL_W-1:SEL_W]), 2);
        chk("T2_nostall", 32'(o_stall), 0);
        chk("T2_cnt", 32'(o_cnt), 1);

        // T3 youngest wins
        drive(1, 1, 3, 1, 0, 0, 2'b00); tick();
        drive(1, 1, 3, 1, 0, 0, 2'b00); tick();
        drive(1, 0, 0, 1, 3, 0, 2'b01); tick();
        chk("T3_sel", 32'(o_sel[SEL_W-1:0]), 1);
        drive(1, 1, 3, 1, 0, 0, 2'b00); tick();
        drive(1, 1, 3, 2, 0, 0, 2'b00); tick();
        drive(1, 0, 0, 1, 3, 0, 2'b01); tick();
        chk("T3v_stall", 32'(o_stall), 1);
        chk("T3v_sel", 32'(o_sel[SEL_W-1:0]), 0);
        tick();

        // T4 x0 destination and unused source
        drive(1, 1, 0, 1, 0, 0, 2'b00); tick();
        drive(1, 0, 0, 1, 0, 0, 2'b01); tick();
        chk("T4_x0_sel", 32'(o_sel), 0);
        drive(1, 1, 9, 2, 0, 0, 2'b00); tick();
        drive(1, 0, 0, 1, 9, 9, 2'b00); tick();
        chk("T4_unused_sel", 32'(o_sel), 0);
        chk("T4_unused_stall", 32'(o_stall), 0);
        // Latency 0 behaves as 1
        drive(1, 1, 6, 0, 0, 0, 2'b00); tick();
        drive(1, 0, 0, 1, 6, 0, 2'b01); tick();
        chk("lat0_sel", 32'(o_sel[SEL_W-1:0]), 1);

        // T5 multiply with a freeze in the middle of the wait
        drive(1, 1, 4, 4, 0, 0, 2'b00); tick();
        drive(1, 0, 0, 1, 4, 0, 2'b01); tick();
        cnt_a = int'(o_cnt);
        chk("T5_stall_a", 32'(o_stall), 1);
        drive(1, 0, 0, 1, 4, 0, 2'b01, 1'b0); tick(); tick();
        chk("T5_frozen_stall", 32'(o_stall), 1);
        drive(1, 0, 0, 1, 4, 0, 2'b01); tick(); tick(); tick();
        chk("T5_sel", 32'(o_sel[SEL_W-1:0]), 4);
        chk("T5_cnt_delta", 32'(int'(o_cnt) - cnt_a), 3);

        // T6 flush with a load in flight
        drive(1, 1, 8, 2, 0, 0, 2'b00); tick();
        drive(0, 0, 0, 1, 0, 0, 2'b00, 1'b1, 1'b1); tick();
        drive(1, 0, 0, 1, 8, 0, 2'b01); tick();
        chk("T6_flush_sel", 32'(o_sel), 0);
        chk("T6_flush_stall", 32'(o_stall), 0);

        // Async reset while a consumer is stalled
        drive(1, 1, 7, 2, 0, 0, 2'b00); tick();
        drive(1, 0, 0, 1, 0, 7, 2'b10);
        #2;
        rst_i = 1'b0;
        #1;
        model_reset();
        chk("arst_stall", 32'(sbif.stall_o), 0);
        chk("arst_haz", 32'(sbif.hazard_o), 0);
        chk("arst_cnt", 32'(sbif.stall_cnt_o), 0);
        tick();
        rst_i = 1'b1;
        tick();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            drive(($urandom_range(0, 9) < 7), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 39) == 0));
            tick();
        end

        // Drive the counter to saturation with repeated multiply-use pairs
        for (int n = 0; n < 30; n++) begin
            drive(1, 1, 4, 4, 0, 0, 2'b00); tick();
            drive(1, 0, 0, 1, 4, 0, 2'b01); repeat (4) tick();
        end
        chk("sat_cnt", 32'(o_cnt), 32'(CNT_MAX));
        drive(1, 1, 4, 4, 0, 0, 2'b00); tick();
        drive(1, 0, 0, 1, 4, 0, 2'b01); tick(); tick();
        chk("sat_hold", 32'(o_cnt), 32'(CNT_MAX));
        chk("sat_stall", 32'(o_stall), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end
endmodule
